// File: rtl/av_mailbox_pkg.sv
// av_mailbox_pkg: shared constants and FSM state type for the Avalon mailbox.
// Holds register addresses, STATUS/CONTROL bit positions and the count width.
package av_mailbox_pkg;

    localparam int CNT_W = 5;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_TX,
        ST_WAIT_RX
    } state_t;

    localparam int STAT_TX_FULL   = 15;
    localparam int STAT_TX_EMPTY  = 14;
    localparam int STAT_RX_FULL   = 13;
    localparam int STAT_RX_EMPTY  = 12;
    localparam int STAT_OVF       = 11;
    localparam int STAT_UNF       = 10;
    localparam int STAT_RXCNT_LSB = 5;
    localparam int STAT_TXCNT_LSB = 0;

    localparam int CTRL_FLUSH_TX   = 0;
    localparam int CTRL_FLUSH_RX   = 1;
    localparam int CTRL_CLR_STICKY = 2;
    localparam int CTRL_IRQ_EN     = 3;

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: synchronous FIFO with registered full/empty flags and flush.
// Ports: i_clk, i_rst_n (sync, active low), i_push/i_pop/i_flush, i_wdata,
//        o_rdata (head), o_full, o_empty, o_count (0..DEPTH).
import av_mailbox_pkg::*;

module mbox_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Flags are registered, so a push while full is refused even if a
    // pop frees a slot in the same cycle.
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 5'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 5'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/av_mailbox_slave.sv
// av_mailbox_slave: Avalon-MM mailbox, DATA writes feed TX stream, RX stream
// feeds DATA reads; STATUS/CONTROL registers; waitrequest-stalled access.
// Ports: sysclk, sysreset_n (sync, active low), av_* Avalon slave,
//        tx_* stream out, rx_* stream in, irq when AV_MAILBOX_IRQ_EN defined.
import av_mailbox_pkg::*;

module av_mailbox_slave #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic        sysclk,
    input  logic        sysreset_n,
    input  logic [1:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic [15:0] av_writedata,
    output logic [15:0] av_readdata,
    output logic        av_waitrequest,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef AV_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_t      r_state;
    logic        r_waitreq;
    logic [15:0] r_readdata;
    logic [15:0] r_timer;
    logic        r_ovf;
    logic        r_unf;
    logic        r_irq_en;

    logic             w_tx_full;
    logic             w_tx_empty;
    logic [CNT_W-1:0] w_tx_count;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [CNT_W-1:0] w_rx_count;
    logic [15:0]      w_rx_head;

    logic        w_idle;
    logic        w_ctrl_wr;
    logic        w_tx_push;
    logic        w_rx_pop;
    logic        w_tx_flush;
    logic        w_rx_flush;
    logic [15:0] w_status;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_ctrl_wr = w_idle && av_write && (av_address == ADDR_CTRL);

    // FIFO side effects are decoded combinationally so they land on the
    // same edge at which the FSM commits the transaction.
    assign w_tx_push = !w_tx_full && av_write &&
                       ((w_idle && av_address == ADDR_DATA) ||
                        r_state == ST_WAIT_TX);
    assign w_rx_pop  = !w_rx_empty && av_read &&
                       ((w_idle && !av_write && av_address == ADDR_DATA) ||
                        r_state == ST_WAIT_RX);

    assign w_tx_flush = w_ctrl_wr && av_writedata[CTRL_FLUSH_TX];
    assign w_rx_flush = w_ctrl_wr && av_writedata[CTRL_FLUSH_RX];

    mbox_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_tx_fifo (
        .i_clk   (sysclk),
        .i_rst_n (sysreset_n),
        .i_push  (w_tx_push),
        .i_pop   (tx_ready),
        .i_flush (w_tx_flush),
        .i_wdata (av_writedata),
        .o_rdata (tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    mbox_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_rx_fifo (
        .i_clk   (sysclk),
        .i_rst_n (sysreset_n),
        .i_push  (rx_valid),
        .i_pop   (w_rx_pop),
        .i_flush (w_rx_flush),
        .i_wdata (rx_data),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    always_comb begin
        w_status = '0;
        w_status[STAT_TX_FULL]  = w_tx_full;
        w_status[STAT_TX_EMPTY] = w_tx_empty;
        w_status[STAT_RX_FULL]  = w_rx_full;
        w_status[STAT_RX_EMPTY] = w_rx_empty;
        w_status[STAT_OVF]      = r_ovf;
        w_status[STAT_UNF]      = r_unf;
        w_status[STAT_RXCNT_LSB +: CNT_W] = w_rx_count;
        w_status[STAT_TXCNT_LSB +: CNT_W] = w_tx_count;
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_state    <= ST_IDLE;
            r_waitreq  <= 1'b1;
            r_readdata <= '0;
            r_timer    <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            r_waitreq <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (av_write) begin
                        r_state   <= ST_ACK;
                        r_waitreq <= 1'b0;
                        case (av_address)
                            ADDR_DATA: begin
                                if (w_tx_full) begin
                                    r_state   <= ST_WAIT_TX;
                                    r_waitreq <= 1'b1;
                                    r_timer   <= 16'(TIMEOUT);
                                end
                            end
                            ADDR_CTRL: begin
                                if (av_writedata[CTRL_CLR_STICKY]) begin
                                    r_ovf <= 1'b0;
                                    r_unf <= 1'b0;
                                end
                                r_irq_en <= av_writedata[CTRL_IRQ_EN];
                            end
                            default: ;
                        endcase
                        // Colliding read+write: write is served, read is
                        // lost and flagged as an underflow.
                        if (av_read) begin
                            r_unf <= 1'b1;
                        end
                    end else if (av_read) begin
                        r_state   <= ST_ACK;
                        r_waitreq <= 1'b0;
                        case (av_address)
                            ADDR_DATA: begin
                                if (w_rx_empty) begin
                                    r_state   <= ST_WAIT_RX;
                                    r_waitreq <= 1'b1;
                                    r_timer   <= 16'(TIMEOUT);
                                end else begin
                                    r_readdata <= w_rx_head;
                                end
                            end
                            ADDR_STATUS: r_readdata <= w_status;
                            ADDR_CTRL:   r_readdata <= {15'b0, r_irq_en};
                            default:     r_readdata <= '0;
                        endcase
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                ST_WAIT_TX: begin
                    if (!av_write) begin
                        r_state <= ST_IDLE;
                    end else if (!w_tx_full) begin
                        r_state   <= ST_ACK;
                        r_waitreq <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_ovf     <= 1'b1;
                        r_state   <= ST_ACK;
                        r_waitreq <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_WAIT_RX: begin
                    if (!av_read) begin
                        r_state <= ST_IDLE;
                    end else if (!w_rx_empty) begin
                        r_readdata <= w_rx_head;
                        r_state    <= ST_ACK;
                        r_waitreq  <= 1'b0;
                    end else if (r_timer == '0) begin
                        r_readdata <= '0;
                        r_unf      <= 1'b1;
                        r_state    <= ST_ACK;
                        r_waitreq  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AV_MAILBOX_IRQ_EN
    logic r_irq;

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (!w_rx_empty || r_ovf || r_unf);
        end
    end

    assign irq = r_irq;
`endif

    assign av_readdata    = r_readdata;
    assign av_waitrequest = r_waitreq;
    assign tx_valid       = !w_tx_empty;
    assign rx_ready       = !w_rx_full;

endmodule
